// File: rtl/comp_weight_buffer.sv
// comp_weight_buffer
// Holds the 3-bit compensation weights and row indices produced by the weight-reduction
// unit, three slots per systolic column (slot address = col*3 + slot). Contents are
// served by 1-cycle random column reads or by a drain FSM that streams every column.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   Load_Start                  clears valid bits, Entry_Count and Overflow
//   Compensation_out_valid      write strobe; Compensation_Mem_Wr_Addr/_Weight/_Row payload
//   Rd_En, Rd_Col               random column read request
//   Drain_Start                 starts sequential drain of all columns
//   Out_Valid, Out_Col          output bundle valid / column
//   Out_Slot_Valid, Out_Weight, Out_Row   per-slot bundle {slot2, slot1, slot0}
//   Drain_Busy, Drain_Done      drain status
//   Overflow                    sticky: overwrite of a valid slot or out-of-range write
//   Entry_Count                 number of valid slots
module comp_weight_buffer #(
   parameter int unsigned SIZE            = 8,
   parameter int unsigned CROW_WIDTH      = $clog2(SIZE),
   parameter int unsigned CMEM_SIZE       = SIZE * 3,
   parameter int unsigned CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE),
   parameter int unsigned COL_WIDTH       = $clog2(SIZE)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         Load_Start,
   input  logic                         Compensation_out_valid,
   input  logic [CMEM_ADDR_WIDTH-1:0]   Compensation_Mem_Wr_Addr,
   input  logic [2:0]                   Compensation_Weight,
   input  logic [CROW_WIDTH-1:0]        Compensation_Row,
   input  logic                         Rd_En,
   input  logic [COL_WIDTH-1:0]         Rd_Col,
   input  logic                         Drain_Start,
   output logic                         Out_Valid,
   output logic [COL_WIDTH-1:0]         Out_Col,
   output logic [2:0]                   Out_Slot_Valid,
   output logic [8:0]                   Out_Weight,
   output logic [3*CROW_WIDTH-1:0]      Out_Row,
   output logic                         Drain_Busy,
   output logic                         Drain_Done,
   output logic                         Overflow,
   output logic [CMEM_ADDR_WIDTH:0]     Entry_Count
);

   localparam int unsigned SLOTS = 3;
   localparam int unsigned WT_W  = 3;
   // col*3+2 always fits in COL_WIDTH+2 bits, so slot addresses never wrap
   localparam int unsigned SA_W  = COL_WIDTH + 2;
   localparam int unsigned EC_W  = CMEM_ADDR_WIDTH + 1;
   localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(SIZE - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   // ---------------------------------------------------------------- storage
   logic [WT_W-1:0]       wt_mem  [CMEM_SIZE];
   logic [CROW_WIDTH-1:0] row_mem [CMEM_SIZE];
   logic [CMEM_SIZE-1:0]  valid_q;
   logic [CMEM_SIZE-1:0]  valid_clr;
   logic [CMEM_SIZE-1:0]  valid_nx;
   logic                  wr_in_range;
   logic                  wr_ok;
   logic                  wr_hit;
   logic                  overflow_nx;
   logic [EC_W-1:0]       count_nx;

   assign wr_in_range = {1'b0, Compensation_Mem_Wr_Addr} < EC_W'(CMEM_SIZE);
   assign wr_ok       = Compensation_out_valid & wr_in_range;

   // Load_Start clears first, then the same-cycle write lands on the cleared image
   always_comb begin
      valid_clr = Load_Start ? '0 : valid_q;
      valid_nx  = valid_clr;
      wr_hit    = 1'b0;
      if (wr_ok) begin
         wr_hit                              = valid_clr[Compensation_Mem_Wr_Addr];
         valid_nx[Compensation_Mem_Wr_Addr]  = 1'b1;
      end
   end

   assign overflow_nx = (Load_Start ? 1'b0 : Overflow)
                      | (Compensation_out_valid & (~wr_in_range | wr_hit));
   assign count_nx    = (Load_Start ? '0 : Entry_Count) + EC_W'(wr_ok & ~wr_hit);

   // Valid bits and bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         Overflow    <= 1'b0;
         Entry_Count <= '0;
      end else begin
         valid_q     <= valid_nx;
         Overflow    <= overflow_nx;
         Entry_Count <= count_nx;
      end
   end

   // Payload storage; contents are qualified by valid_q so no reset is needed
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         wt_mem[Compensation_Mem_Wr_Addr]  <= Compensation_Weight;
         row_mem[Compensation_Mem_Wr_Addr] <= Compensation_Row;
      end
   end

   // ---------------------------------------------------------------- drain FSM
   state_t               state_q;
   state_t               state_nx;
   logic [COL_WIDTH-1:0] cnt_q;
   logic [COL_WIDTH-1:0] cnt_nx;
   logic                 drain_rd;
   logic                 done_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         Drain_Busy <= 1'b0;
         Drain_Done <= 1'b0;
      end else begin
         state_q    <= state_nx;
         cnt_q      <= cnt_nx;
         Drain_Busy <= (state_nx != IDLE);
         Drain_Done <= done_nx;
      end
   end

   // Next state; Drain_Done is raised when the last column read is issued so it
   // lines up with that column's bundle one cycle later
   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      drain_rd = 1'b0;
      done_nx  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Drain_Start) begin
               state_nx = DRAIN;
               cnt_nx   = '0;
            end
         end
         DRAIN: begin
            drain_rd = 1'b1;
            cnt_nx   = cnt_q + COL_WIDTH'(1);
            if (cnt_q == LAST_COL) begin
               state_nx = DONE;
               done_nx  = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- read path
   logic                    rd_req;
   logic [COL_WIDTH-1:0]    rd_col;
   logic [SA_W-1:0]         rd_base;
   logic [SA_W-1:0]         slot_a;
   logic [SLOTS-1:0]        rd_valid;
   logic [8:0]              rd_weight;
   logic [3*CROW_WIDTH-1:0] rd_row;

   // The drain owns the read port while active; Rd_Col is then ignored
   assign rd_req  = drain_rd | Rd_En;
   assign rd_col  = drain_rd ? cnt_q : Rd_Col;
   assign rd_base = (SA_W'(rd_col) << 1) + SA_W'(rd_col);

   // Column gather with write-first forwarding from the same-cycle write
   always_comb begin
      rd_valid  = '0;
      rd_weight = '0;
      rd_row    = '0;
      slot_a    = '0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
         slot_a = rd_base + SA_W'(k);
         if (slot_a < SA_W'(CMEM_SIZE)) begin
            rd_valid[k] = valid_nx[slot_a];
            if (wr_ok && (SA_W'(Compensation_Mem_Wr_Addr) == slot_a)) begin
               rd_weight[k*WT_W +: WT_W]            = Compensation_Weight;
               rd_row[k*CROW_WIDTH +: CROW_WIDTH]   = Compensation_Row;
            end else begin
               rd_weight[k*WT_W +: WT_W]            = wt_mem[slot_a];
               rd_row[k*CROW_WIDTH +: CROW_WIDTH]   = row_mem[slot_a];
            end
         end
      end
   end

   // Output bundle; holds its last value when no read is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Out_Valid      <= 1'b0;
         Out_Col        <= '0;
         Out_Slot_Valid <= '0;
         Out_Weight     <= '0;
         Out_Row        <= '0;
      end else begin
         Out_Valid <= rd_req;
         if (rd_req) begin
            Out_Col        <= rd_col;
            Out_Slot_Valid <= rd_valid;
            Out_Weight     <= rd_weight;
            Out_Row        <= rd_row;
         end
      end
   end

endmodule

// File: tb/tb_comp_weight_buffer.sv
// tb_comp_weight_buffer
// Directed vector table, hand-written drain / reset-mid-drain sequences and a random
// phase, all compared against a slot-array reference model of the buffer.
module tb_comp_weight_buffer;

   localparam int unsigned SIZE  = 8;
   localparam int unsigned NSLOT = SIZE * 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ld, wv, re, ds;
   logic [4:0] wa;
   logic [2:0] ww, wrow, rc;

   logic       Out_Valid, Drain_Busy, Drain_Done, Overflow;
   logic [2:0] Out_Col, Out_Slot_Valid;
   logic [8:0] Out_Weight, Out_Row;
   logic [5:0] Entry_Count;

   comp_weight_buffer #(.SIZE(SIZE)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .Load_Start               (ld),
      .Compensation_out_valid   (wv),
      .Compensation_Mem_Wr_Addr (wa),
      .Compensation_Weight      (ww),
      .Compensation_Row         (wrow),
      .Rd_En                    (re),
      .Rd_Col                   (rc),
      .Drain_Start              (ds),
      .Out_Valid                (Out_Valid),
      .Out_Col                  (Out_Col),
      .Out_Slot_Valid           (Out_Slot_Valid),
      .Out_Weight               (Out_Weight),
      .Out_Row                  (Out_Row),
      .Drain_Busy               (Drain_Busy),
      .Drain_Done               (Drain_Done),
      .Overflow                 (Overflow),
      .Entry_Count              (Entry_Count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------ reference model
   bit         m_valid [NSLOT];
   logic [2:0] m_wt    [NSLOT];
   logic [2:0] m_row   [NSLOT];
   bit         m_ovf, m_busy, m_done;
   int         m_issue;            // column the drain reads this cycle, -1 if none
   logic       x_ov;
   logic [2:0] x_col, x_sv;
   logic [8:0] x_wt, x_row;

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < NSLOT; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NSLOT; i++) m_valid[i] = 1'b0;
      m_ovf = 0; m_busy = 0; m_done = 0; m_issue = -1;
      x_ov = 0; x_col = '0; x_sv = '0; x_wt = '0; x_row = '0;
   endtask

   // Applies one clock edge worth of behaviour using the inputs held this cycle
   task automatic model_edge();
      bit drn, rd;
      int col, a;
      if (!rst_n) return;
      drn = (m_issue >= 0);
      rd  = drn ? 1'b1 : re;
      col = drn ? m_issue : int'(rc);
      if (ld) begin
         for (int i = 0; i < NSLOT; i++) m_valid[i] = 1'b0;
         m_ovf = 0;
      end
      if (wv) begin
         if (int'(wa) >= NSLOT) m_ovf = 1;
         else begin
            if (m_valid[wa]) m_ovf = 1;
            m_valid[wa] = 1'b1;
            m_wt[wa]    = ww;
            m_row[wa]   = wrow;
         end
      end
      x_ov = rd;
      if (rd) begin
         x_col = 3'(col);
         for (int k = 0; k < 3; k++) begin
            a = col * 3 + k;
            x_sv[k]          = m_valid[a];
            x_wt[3*k +: 3]   = m_wt[a];
            x_row[3*k +: 3]  = m_row[a];
         end
      end
      m_done = 0;
      if (drn) begin
         if (m_issue == SIZE - 1) begin m_issue = -1; m_done = 1; end
         else m_issue++;
      end else if (m_busy) m_busy = 0;
      else if (ds) begin m_busy = 1; m_issue = 0; end
   endtask

   task automatic check_model();
      logic [8:0] m;
      m = {{3{x_sv[2]}}, {3{x_sv[1]}}, {3{x_sv[0]}}};
      chk("out_valid",   32'(Out_Valid),      32'(x_ov));
      chk("out_col",     32'(Out_Col),        32'(x_col));
      chk("slot_valid",  32'(Out_Slot_Valid), 32'(x_sv));
      chk("weight",      32'(Out_Weight & m), 32'(x_wt & m));
      chk("row",         32'(Out_Row & m),    32'(x_row & m));
      chk("busy",        32'(Drain_Busy),     32'(m_busy));
      chk("done",        32'(Drain_Done),     32'(m_done));
      chk("overflow",    32'(Overflow),       32'(m_ovf));
      chk("entry_count", 32'(Entry_Count),    32'(model_count()));
   endtask

   task automatic step(input logic i_ld, input logic i_wv, input logic [4:0] i_wa,
                       input logic [2:0] i_ww, input logic [2:0] i_wr, input logic i_re,
                       input logic [2:0] i_rc, input logic i_ds);
      ld = i_ld; wv = i_wv; wa = i_wa; ww = i_ww; wrow = i_wr;
      re = i_re; rc = i_rc; ds = i_ds;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ------------------------------------------------------------ vector table
   typedef struct {
      logic       ld, wv;
      logic [4:0] wa;
      logic [2:0] ww, wr;
      logic       re;
      logic [2:0] rc;
      logic       e_ov;
      logic [2:0] e_sv;
      logic [8:0] e_wt, e_row;
      logic       e_ovf;
      logic [5:0] e_cnt;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   function automatic vec_t mk(input logic a_ld, input logic a_wv, input logic [4:0] a_wa,
                               input logic [2:0] a_ww, input logic [2:0] a_wr, input logic a_re,
                               input logic [2:0] a_rc, input logic a_ov, input logic [2:0] a_sv,
                               input logic [8:0] a_wt, input logic [8:0] a_row,
                               input logic a_ovf, input logic [5:0] a_cnt);
      vec_t v;
      v.ld = a_ld; v.wv = a_wv; v.wa = a_wa; v.ww = a_ww; v.wr = a_wr;
      v.re = a_re; v.rc = a_rc; v.e_ov = a_ov; v.e_sv = a_sv;
      v.e_wt = a_wt; v.e_row = a_row; v.e_ovf = a_ovf; v.e_cnt = a_cnt;
      return v;
   endfunction

   // Drain of all columns; populated selects cols 0 and 7 holding slots {0,2} / {0,1}
   task automatic run_drain(input bit populated);
      int ncols, ndone;
      logic [2:0] em;
      ncols = 0; ndone = 0;
      step(0, 0, '0, '0, '0, 0, '0, 1);
      check_model();
      for (int i = 0; i < 10; i++) begin
         step(0, 0, '0, '0, '0, (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0,
              3'($urandom_range(0, 7)), 0);
         check_model();
         if (Drain_Busy && Out_Valid) begin
            em = 3'b000;
            if (populated && ncols == 0) em = 3'b101;
            if (populated && ncols == 7) em = 3'b011;
            chk("drain_col",  32'(Out_Col),        32'(ncols));
            chk("drain_mask", 32'(Out_Slot_Valid), 32'(em));
            ncols++;
         end
         if (Drain_Done) begin
            ndone++;
            chk("done_col", 32'(Out_Col), 32'(SIZE - 1));
         end
      end
      chk("drain_len",  32'(ncols), 32'(SIZE));
      chk("done_count", 32'(ndone), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int ndone;
      logic [8:0] vm;

      //            ld wv wa  ww wr re rc  ov  sv      wt                   row                  ovf cnt
      vt[0]  = mk(0, 0, 0,  0, 0, 1, 0,  1, 3'b000, 9'd0,                9'd0,                0, 0);
      vt[1]  = mk(0, 1, 3,  5, 2, 0, 0,  0, 3'b000, 9'd0,                9'd0,                0, 1);
      vt[2]  = mk(0, 1, 4,  1, 7, 0, 0,  0, 3'b000, 9'd0,                9'd0,                0, 2);
      vt[3]  = mk(0, 0, 0,  0, 0, 1, 1,  1, 3'b011, {3'd0, 3'd1, 3'd5}, {3'd0, 3'd7, 3'd2}, 0, 2);
      vt[4]  = mk(0, 1, 23, 6, 4, 1, 7,  1, 3'b100, {3'd6, 3'd0, 3'd0}, {3'd4, 3'd0, 3'd0}, 0, 3);
      vt[5]  = mk(0, 1, 3,  3, 1, 0, 0,  0, 3'b100, {3'd6, 3'd0, 3'd0}, {3'd4, 3'd0, 3'd0}, 1, 3);
      vt[6]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 3'b100, {3'd6, 3'd0, 3'd0}, {3'd4, 3'd0, 3'd0}, 1, 3);
      vt[7]  = mk(0, 0, 0,  0, 0, 1, 1,  1, 3'b011, {3'd0, 3'd1, 3'd3}, {3'd0, 3'd7, 3'd1}, 1, 3);
      vt[8]  = mk(1, 1, 4,  7, 3, 1, 1,  1, 3'b010, {3'd0, 3'd7, 3'd0}, {3'd0, 3'd3, 3'd0}, 0, 1);
      vt[9]  = mk(0, 0, 0,  0, 0, 1, 7,  1, 3'b000, 9'd0,                9'd0,                0, 1);
      vt[10] = mk(0, 1, 24, 2, 2, 0, 0,  0, 3'b000, 9'd0,                9'd0,                1, 1);
      vt[11] = mk(0, 1, 31, 2, 2, 0, 0,  0, 3'b000, 9'd0,                9'd0,                1, 1);
      vt[12] = mk(1, 0, 0,  0, 0, 0, 0,  0, 3'b000, 9'd0,                9'd0,                0, 0);

      rst_n = 1'b0;
      ld = 0; wv = 0; wa = '0; ww = '0; wrow = '0; re = 0; rc = '0; ds = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_model();
      #3 rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < NV; i++) begin
         step(vt[i].ld, vt[i].wv, vt[i].wa, vt[i].ww, vt[i].wr, vt[i].re, vt[i].rc, 1'b0);
         vm = {{3{vt[i].e_sv[2]}}, {3{vt[i].e_sv[1]}}, {3{vt[i].e_sv[0]}}};
         chk($sformatf("vec%0d_out_valid", i), 32'(Out_Valid), 32'(vt[i].e_ov));
         if (vt[i].e_ov) begin
            chk($sformatf("vec%0d_col", i),    32'(Out_Col),         32'(vt[i].rc));
            chk($sformatf("vec%0d_weight", i), 32'(Out_Weight & vm), 32'(vt[i].e_wt & vm));
            chk($sformatf("vec%0d_row", i),    32'(Out_Row & vm),    32'(vt[i].e_row & vm));
         end
         chk($sformatf("vec%0d_slot_valid", i), 32'(Out_Slot_Valid), 32'(vt[i].e_sv));
         chk($sformatf("vec%0d_overflow", i),   32'(Overflow),       32'(vt[i].e_ovf));
         chk($sformatf("vec%0d_count", i),      32'(Entry_Count),    32'(vt[i].e_cnt));
         chk($sformatf("vec%0d_busy", i),       32'(Drain_Busy),     32'(0));
      end

      // Populate columns 0 and 7, then drain with Rd_En noise
      step(1, 1, 5'd0,  3'd5, 3'd1, 0, '0, 0); check_model();
      step(0, 1, 5'd2,  3'd2, 3'd6, 0, '0, 0); check_model();
      step(0, 1, 5'd21, 3'd7, 3'd3, 0, '0, 0); check_model();
      step(0, 1, 5'd22, 3'd4, 3'd5, 0, '0, 0); check_model();
      run_drain(1);

      // Reset while the drain is presenting column 3
      step(0, 0, '0, '0, '0, 0, '0, 1);
      check_model();
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         step(0, 0, '0, '0, '0, 0, '0, 0);
         check_model();
         if (Out_Valid && Out_Col == 3'd3) found = 1;
      end
      chk("reach_col3", 32'(found), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_out_valid",  32'(Out_Valid),      32'(0));
      chk("rst_out_col",    32'(Out_Col),        32'(0));
      chk("rst_slot_valid", 32'(Out_Slot_Valid), 32'(0));
      chk("rst_weight",     32'(Out_Weight),     32'(0));
      chk("rst_row",        32'(Out_Row),        32'(0));
      chk("rst_busy",       32'(Drain_Busy),     32'(0));
      chk("rst_done",       32'(Drain_Done),     32'(0));
      chk("rst_overflow",   32'(Overflow),       32'(0));
      chk("rst_count",      32'(Entry_Count),    32'(0));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, '0, '0, '0, 0, '0, 0);
         check_model();
         if (Drain_Done) ndone++;
      end
      chk("no_done_after_rst", 32'(ndone), 32'(0));
      run_drain(0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 26)), 3'($urandom), 3'($urandom),
              1'($urandom_range(0, 2) == 0), 3'($urandom),
              1'($urandom_range(0, 15) == 0));
         check_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
